// File: rtl/scm_mc_pkg.sv
// scm_mc_pkg: shared constants for the multi-channel statistics block.
//   - MD/PHV field positions used by the datapath and counters
//   - configuration ring beat layout, op codes and the response code
//   - register map (base address, global and per-channel offsets)
//   - reset value for the per-channel latency minimum
package scm_mc_pkg;

   localparam int MD_LEN_HI   = 107;
   localparam int MD_LEN_LO   = 96;
   localparam int MD_ID_HI    = 87;
   localparam int MD_ID_LO    = 80;
   localparam int MD_PROTO_HI = 79;
   localparam int MD_PROTO_LO = 72;
   localparam int PHV_TS_HI   = 703;
   localparam int PHV_TS_LO   = 672;

   localparam int HDR_HI  = 133;
   localparam int HDR_LO  = 132;
   localparam int RSP_HI  = 127;
   localparam int RSP_LO  = 124;
   localparam int OP_HI   = 126;
   localparam int OP_LO   = 124;
   localparam int SRC_HI  = 111;
   localparam int SRC_LO  = 104;
   localparam int DST_HI  = 103;
   localparam int DST_LO  = 96;
   localparam int ADDR_HI = 95;
   localparam int ADDR_LO = 64;

   localparam logic [1:0] HDR_FIRST = 2'b01;
   localparam logic [1:0] HDR_LAST  = 2'b10;
   localparam logic [2:0] OP_WRITE  = 3'b010;
   localparam logic [2:0] OP_READ   = 3'b001;
   localparam logic [3:0] OP_RSP    = 4'b1011;

   localparam logic [31:0] BASE_ADDR    = 32'h7000_0000;
   localparam logic [3:0]  GREG_CLEAR   = 4'd0;
   localparam logic [3:0]  GREG_MASK    = 4'd1;
   localparam logic [3:0]  REG_PROTO    = 4'd0;
   localparam logic [3:0]  REG_BYTES_LO = 4'd1;
   localparam logic [3:0]  REG_BYTES_HI = 4'd2;
   localparam logic [3:0]  REG_PKTS_LO  = 4'd3;
   localparam logic [3:0]  REG_PKTS_HI  = 4'd4;
   localparam logic [3:0]  REG_LAT_MIN  = 4'd5;
   localparam logic [3:0]  REG_LAT_MAX  = 4'd6;

   localparam logic [31:0] LAT_MIN_RST = 32'hFFFF_FFFF;
   localparam logic [31:0] RD_UNMAPPED = 32'hFFFF_FFFF;

   typedef struct packed {
      logic        first;
      logic        last;
      logic [2:0]  op;
      logic [7:0]  src;
      logic [7:0]  dst;
      logic [31:0] addr;
   } cfg_beat_t;

   function automatic cfg_beat_t decode_beat(input logic [133:0] b);
      cfg_beat_t d;
      d.first = (b[HDR_HI:HDR_LO] == HDR_FIRST);
      d.last  = (b[HDR_HI:HDR_LO] == HDR_LAST);
      d.op    = b[OP_HI:OP_LO];
      d.src   = b[SRC_HI:SRC_LO];
      d.dst   = b[DST_HI:DST_LO];
      d.addr  = b[ADDR_HI:ADDR_LO];
      return d;
   endfunction

endpackage

// File: rtl/scm_mc_if.sv
// scm_mc_if: MD/PHV pipeline stream (metadata + PHV beats, valid, almost-full).
//   master drives md/md_wr/phv/phv_wr and receives md_alf/phv_alf.
// scm_mc_cfg_if: 134-bit configuration ring stream.
//   master drives data/data_wr and receives ready.
interface scm_mc_if;
   logic [255:0]  md;
   logic          md_wr;
   logic          md_alf;
   logic [1023:0] phv;
   logic          phv_wr;
   logic          phv_alf;

   modport master (output md, md_wr, phv, phv_wr, input md_alf, phv_alf);
   modport slave  (input md, md_wr, phv, phv_wr, output md_alf, phv_alf);
endinterface

interface scm_mc_cfg_if;
   logic [133:0] data;
   logic         data_wr;
   logic         ready;

   modport master (output data, data_wr, input ready);
   modport slave  (input data, data_wr, output ready);
endinterface

// File: rtl/scm_mc_chan.sv
// scm_mc_chan: one statistics channel.
//   clk, rst_n          clock, async active-low reset
//   hit                 count this cycle's packet
//   clear               zero counters and latency min/max (wins over hit)
//   len, lat            packet length and latency of the current packet
//   proto_we/_wdata     protocol register write
//   snap_bytes/_pkts    lo-word read strobes; latch the upper counter bits
//   proto, *_lo, *_shadow, lat_min, lat_max   register read values
module scm_mc_chan
   import scm_mc_pkg::*;
#(
   parameter int CNT_W = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hit,
   input  logic        clear,
   input  logic [11:0] len,
   input  logic [31:0] lat,
   input  logic        proto_we,
   input  logic [7:0]  proto_wdata,
   input  logic        snap_bytes,
   input  logic        snap_pkts,
   output logic [7:0]  proto,
   output logic [31:0] bytes_lo,
   output logic [31:0] bytes_shadow,
   output logic [31:0] pkts_lo,
   output logic [31:0] pkts_shadow,
   output logic [31:0] lat_min,
   output logic [31:0] lat_max
);

   logic [CNT_W-1:0] bytes_q;
   logic [CNT_W-1:0] pkts_q;

   assign bytes_lo = bytes_q[31:0];
   assign pkts_lo  = pkts_q[31:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        proto <= '0;
      else if (proto_we) proto <= proto_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bytes_q <= '0;
         pkts_q  <= '0;
         lat_min <= LAT_MIN_RST;
         lat_max <= '0;
      end else if (clear) begin
         bytes_q <= '0;
         pkts_q  <= '0;
         lat_min <= LAT_MIN_RST;
         lat_max <= '0;
      end else if (hit) begin
         bytes_q <= bytes_q + CNT_W'(len);
         pkts_q  <= pkts_q + CNT_W'(1);
         if (lat < lat_min) lat_min <= lat;
         if (lat > lat_max) lat_max <= lat;
      end
   end

   // Shadows capture the register value before any same-cycle update, so the
   // lo word returned by the read and the hi word captured here stay coherent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bytes_shadow <= '0;
         pkts_shadow  <= '0;
      end else begin
         if (snap_bytes) bytes_shadow <= 32'(bytes_q >> 32);
         if (snap_pkts)  pkts_shadow  <= 32'(pkts_q >> 32);
      end
   end

endmodule

// File: rtl/scm_mc.sv
// scm_mc: multi-channel hardware statistics, inline on the MD/PHV pipeline
// and on the configuration ring.
//   clk, rst_n            clock, async active-low reset
//   pin  (slave)          MD/PHV from upstream, almost-full back to upstream
//   pout (master)         MD/PHV to next module, almost-full from downstream
//   gac2scm_sent_start    counting window open
//   cin  (slave)          configuration beats in, ready back upstream
//   cout (master)         configuration beats out, ready from downstream
//   um2scm_timestamp      free-running timestamp for latency
//
// Control FSM
//   state    | meaning
//   IDLE     | waiting for beat 1 (stray beat 2 is forwarded)
//   FWD2     | beat 1 forwarded or answered; forward beat 2
//   DROP2    | beat 1 was a local write; swallow beat 2
module scm_mc
   import scm_mc_pkg::*;
#(
   parameter logic [7:0] LMID   = 8'd7,
   parameter logic [7:0] NMID   = 8'd4,
   parameter int         NUM_CH = 4,
   parameter int         CNT_W  = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   scm_mc_if.slave      pin,
   scm_mc_if.master     pout,
   input  logic         gac2scm_sent_start,
   scm_mc_cfg_if.slave  cin,
   scm_mc_cfg_if.master cout,
   input  logic [31:0]  um2scm_timestamp
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FWD2  = 2'd1;
   localparam logic [1:0] ST_DROP2 = 2'd2;

   assign pin.md_alf  = pout.md_alf;
   assign pin.phv_alf = pout.phv_alf;
   assign cin.ready   = cout.ready;

   logic         take;
   logic         id_hit;
   logic         cnt_ok;
   logic [255:0] md_next;
   logic [31:0]  lat;

   assign take   = pin.md_wr & pin.phv_wr;
   assign id_hit = (pin.md[MD_ID_HI:MD_ID_LO] == LMID);
   assign cnt_ok = take & id_hit & gac2scm_sent_start;
   assign lat    = um2scm_timestamp - pin.phv[PHV_TS_HI:PHV_TS_LO];

   always_comb begin
      md_next = pin.md;
      if (id_hit) md_next[MD_ID_HI:MD_ID_LO] = NMID;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pout.md     <= '0;
         pout.md_wr  <= 1'b0;
         pout.phv    <= '0;
         pout.phv_wr <= 1'b0;
      end else if (take) begin
         pout.md     <= md_next;
         pout.md_wr  <= 1'b1;
         pout.phv    <= pin.phv;
         pout.phv_wr <= 1'b1;
      end else begin
         pout.md     <= '0;
         pout.md_wr  <= 1'b0;
         pout.phv    <= '0;
         pout.phv_wr <= 1'b0;
      end
   end

   cfg_beat_t   bt;
   logic        is_first;
   logic        for_me;
   logic        wr_stb;
   logic        rd_stb;
   logic        in_blk;
   logic        glob;
   logic [3:0]  sel;
   logic [3:0]  reg_r;
   logic        clr_pulse;
   logic        mask_we;
   logic [NUM_CH-1:0] en_mask;

   assign bt       = decode_beat(cin.data);
   assign is_first = cin.data_wr & bt.first;
   assign for_me   = (bt.dst == LMID);
   assign wr_stb   = is_first & for_me & (bt.op == OP_WRITE);
   assign rd_stb   = is_first & for_me & (bt.op == OP_READ);
   assign in_blk   = (bt.addr[31:8] == BASE_ADDR[31:8]);
   assign sel      = bt.addr[7:4];
   assign reg_r    = bt.addr[3:0];
   assign glob     = in_blk & (sel == 4'd0);
   // Clear acts in the same cycle as the write beat so it pre-empts any
   // packet counted on that edge.
   assign clr_pulse = wr_stb & glob & (reg_r == GREG_CLEAR) & cin.data[0];
   assign mask_we   = wr_stb & glob & (reg_r == GREG_MASK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       en_mask <= '0;
      else if (mask_we) en_mask <= cin.data[NUM_CH-1:0];
   end

   logic [NUM_CH-1:0] ch_sel;
   logic [NUM_CH-1:0] ch_hit;
   logic [NUM_CH-1:0] proto_we;
   logic [NUM_CH-1:0] snap_b;
   logic [NUM_CH-1:0] snap_p;
   logic [7:0]  ch_proto   [NUM_CH];
   logic [31:0] ch_bytes   [NUM_CH];
   logic [31:0] ch_bytes_s [NUM_CH];
   logic [31:0] ch_pkts    [NUM_CH];
   logic [31:0] ch_pkts_s  [NUM_CH];
   logic [31:0] ch_lat_min [NUM_CH];
   logic [31:0] ch_lat_max [NUM_CH];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
      // Channel c lives at register block c+1; block 0 is the global block.
      assign ch_sel[c]   = in_blk & (sel == 4'(c + 1));
      assign ch_hit[c]   = cnt_ok & en_mask[c] &
                           (ch_proto[c] == pin.md[MD_PROTO_HI:MD_PROTO_LO]);
      assign proto_we[c] = wr_stb & ch_sel[c] & (reg_r == REG_PROTO);
      assign snap_b[c]   = rd_stb & ch_sel[c] & (reg_r == REG_BYTES_LO);
      assign snap_p[c]   = rd_stb & ch_sel[c] & (reg_r == REG_PKTS_LO);

      scm_mc_chan #(.CNT_W(CNT_W)) u_chan (
         .clk          (clk),
         .rst_n        (rst_n),
         .hit          (ch_hit[c]),
         .clear        (clr_pulse),
         .len          (pin.md[MD_LEN_HI:MD_LEN_LO]),
         .lat          (lat),
         .proto_we     (proto_we[c]),
         .proto_wdata  (cin.data[7:0]),
         .snap_bytes   (snap_b[c]),
         .snap_pkts    (snap_p[c]),
         .proto        (ch_proto[c]),
         .bytes_lo     (ch_bytes[c]),
         .bytes_shadow (ch_bytes_s[c]),
         .pkts_lo      (ch_pkts[c]),
         .pkts_shadow  (ch_pkts_s[c]),
         .lat_min      (ch_lat_min[c]),
         .lat_max      (ch_lat_max[c])
      );
   end

   logic [31:0]  rdata;
   logic [133:0] rsp;

   always_comb begin
      rdata = RD_UNMAPPED;
      if (glob) begin
         if (reg_r == GREG_CLEAR)     rdata = '0;
         else if (reg_r == GREG_MASK) rdata = 32'(en_mask);
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_sel[c]) begin
            case (reg_r)
               REG_PROTO:    rdata = {24'd0, ch_proto[c]};
               REG_BYTES_LO: rdata = ch_bytes[c];
               REG_BYTES_HI: rdata = ch_bytes_s[c];
               REG_PKTS_LO:  rdata = ch_pkts[c];
               REG_PKTS_HI:  rdata = ch_pkts_s[c];
               REG_LAT_MIN:  rdata = ch_lat_min[c];
               REG_LAT_MAX:  rdata = ch_lat_max[c];
               default:      rdata = RD_UNMAPPED;
            endcase
         end
      end
   end

   always_comb begin
      rsp                  = cin.data;
      rsp[RSP_HI:RSP_LO]   = OP_RSP;
      rsp[SRC_HI:SRC_LO]   = bt.dst;
      rsp[DST_HI:DST_LO]   = bt.src;
      rsp[31:0]            = rdata;
   end

   logic [1:0] state;

   // A beat 1 always restarts packet handling, whatever the current state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cout.data    <= '0;
         cout.data_wr <= 1'b0;
      end else begin
         cout.data    <= '0;
         cout.data_wr <= 1'b0;
         if (cin.data_wr) begin
            if (bt.first) begin
               if (wr_stb) begin
                  state <= ST_DROP2;
               end else begin
                  state        <= ST_FWD2;
                  cout.data    <= rd_stb ? rsp : cin.data;
                  cout.data_wr <= 1'b1;
               end
            end else if (bt.last) begin
               state <= ST_IDLE;
               if (state != ST_DROP2) begin
                  cout.data    <= cin.data;
                  cout.data_wr <= 1'b1;
               end
            end else begin
               cout.data    <= cin.data;
               cout.data_wr <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_scm_mc.sv
module tb_scm_mc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] ts = 32'd0;

   always #5 clk = ~clk;

   scm_mc_if     pin_if ();
   scm_mc_if     pout_if ();
   scm_mc_cfg_if cin_if ();
   scm_mc_cfg_if cout_if ();

   scm_mc #(.LMID(8'd7), .NMID(8'd4), .NUM_CH(4), .CNT_W(64)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .pin                (pin_if),
      .pout               (pout_if),
      .gac2scm_sent_start (start),
      .cin                (cin_if),
      .cout               (cout_if),
      .um2scm_timestamp   (ts)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] id;
      logic [7:0] proto;
      logic       md_wr;
      logic       phv_wr;
      logic       alf_md;
      logic       alf_phv;
      logic       exp_wr;
      logic [7:0] exp_id;
   } dp_vec_t;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] mk_md(input logic [7:0] id, input logic [7:0] proto,
                                          input logic [11:0] len);
      logic [255:0] m;
      m = {8{32'h1234_5678}};
      m[107:96] = len;
      m[87:80]  = id;
      m[79:72]  = proto;
      return m;
   endfunction

   function automatic logic [1023:0] mk_phv(input logic [31:0] send_ts, input logic [31:0] seed);
      logic [1023:0] p;
      p = {32{seed}};
      p[703:672] = send_ts;
      return p;
   endfunction

   function automatic logic [133:0] mk_b1(input logic [2:0] op, input logic [7:0] src,
                                          input logic [7:0] dst, input logic [31:0] addr,
                                          input logic [31:0] data);
      logic [133:0] b;
      b = '0;
      b[133:132] = 2'b01;
      b[126:124] = op;
      b[123:112] = 12'hABC;
      b[111:104] = src;
      b[103:96]  = dst;
      b[95:64]   = addr;
      b[63:32]   = 32'h5A5A_C3C3;
      b[31:0]    = data;
      return b;
   endfunction

   function automatic logic [133:0] mk_b2();
      logic [133:0] b;
      b = '0;
      b[133:132] = 2'b10;
      b[63:0]    = 64'hDEAD_BEEF_0BAD_F00D;
      return b;
   endfunction

   task automatic cfg_beat(input logic [133:0] b);
      cin_if.data    = b;
      cin_if.data_wr = 1'b1;
      tick();
      cin_if.data    = '0;
      cin_if.data_wr = 1'b0;
   endtask

   task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
      cfg_beat(mk_b1(3'b010, 8'h02, 8'd7, addr, data));
      cfg_beat(mk_b2());
   endtask

   task automatic cfg_read(input string name, input logic [31:0] addr, input logic [31:0] exp_data);
      logic [133:0] b1;
      logic [133:0] exp;
      b1 = mk_b1(3'b001, 8'h02, 8'd7, addr, 32'h0);
      exp = b1;
      exp[127:124] = 4'b1011;
      exp[111:104] = 8'd7;
      exp[103:96]  = 8'h02;
      exp[31:0]    = exp_data;
      cfg_beat(b1);
      chk(name, {cout_if.data_wr, cout_if.data}, {1'b1, exp});
      cfg_beat(mk_b2());
      chk({name, "_b2"}, {cout_if.data_wr, cout_if.data}, {1'b1, mk_b2()});
   endtask

   task automatic send_pkt(input logic [7:0] id, input logic [7:0] proto, input logic [11:0] len,
                           input logic [31:0] send_ts, input logic [31:0] now);
      pin_if.md     = mk_md(id, proto, len);
      pin_if.phv    = mk_phv(send_ts, 32'hC0FF_EE00);
      pin_if.md_wr  = 1'b1;
      pin_if.phv_wr = 1'b1;
      ts            = now;
      tick();
      pin_if.md_wr  = 1'b0;
      pin_if.phv_wr = 1'b0;
   endtask

   dp_vec_t       dv [5];
   logic [255:0]  md_v;
   logic [1023:0] phv_v;
   logic [255:0]  exp_md;
   logic [1023:0] exp_phv;
   logic [133:0]  b1;

   initial begin
      pin_if.md       = '0;
      pin_if.md_wr    = 1'b0;
      pin_if.phv      = '0;
      pin_if.phv_wr   = 1'b0;
      pout_if.md_alf  = 1'b0;
      pout_if.phv_alf = 1'b0;
      cin_if.data     = '0;
      cin_if.data_wr  = 1'b0;
      cout_if.ready   = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_wr", {pout_if.md_wr, pout_if.phv_wr, cout_if.data_wr}, 256'd0);
      chk("rst_md", pout_if.md, 256'd0);
      chk("rst_cdata", {122'd0, cout_if.data}, 256'd0);
      rst_n = 1'b1;
      tick();

      dv[0] = '{8'd7,   8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd4};
      dv[1] = '{8'd3,   8'h11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd3};
      dv[2] = '{8'd7,   8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      dv[3] = '{8'd7,   8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
      dv[4] = '{8'hFF,  8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF};
      for (int i = 0; i < 5; i++) begin
         md_v  = mk_md(dv[i].id, dv[i].proto, 12'd64);
         phv_v = mk_phv(32'h0, 32'h1000_0000 + i);
         pin_if.md       = md_v;
         pin_if.phv      = phv_v;
         pin_if.md_wr    = dv[i].md_wr;
         pin_if.phv_wr   = dv[i].phv_wr;
         pout_if.md_alf  = dv[i].alf_md;
         pout_if.phv_alf = dv[i].alf_phv;
         cout_if.ready   = dv[i].alf_md;
         #1;
         chk("alf_pass", {pin_if.md_alf, pin_if.phv_alf, cin_if.ready},
             {dv[i].alf_md, dv[i].alf_phv, dv[i].alf_md});
         @(posedge clk);
         #1;
         exp_md = md_v;
         exp_md[87:80] = dv[i].exp_id;
         if (!dv[i].exp_wr) exp_md = '0;
         exp_phv = dv[i].exp_wr ? phv_v : '0;
         chk("dp_wr", {pout_if.md_wr, pout_if.phv_wr}, {dv[i].exp_wr, dv[i].exp_wr});
         chk("dp_md", pout_if.md, exp_md);
         chk("dp_phv", 256'(pout_if.phv == exp_phv), 256'd1);
      end
      pin_if.md_wr  = 1'b0;
      pin_if.phv_wr = 1'b0;
      tick();
      chk("dp_idle", {pout_if.md_wr, pout_if.md}, 256'd0);

      b1 = mk_b1(3'b010, 8'h02, 8'd9, 32'h7000_0010, 32'h77);
      cfg_beat(b1);
      chk("fwd_b1", {cout_if.data_wr, cout_if.data}, {1'b1, b1});
      cfg_beat(mk_b2());
      chk("fwd_b2", {cout_if.data_wr, cout_if.data}, {1'b1, mk_b2()});

      cfg_beat(mk_b1(3'b010, 8'h02, 8'd7, 32'h7000_0010, 32'h11));
      chk("own_wr_b1", cout_if.data_wr, 256'd0);
      cfg_beat(mk_b2());
      chk("own_wr_b2", cout_if.data_wr, 256'd0);

      b1 = mk_b1(3'b100, 8'h02, 8'd7, 32'h7000_0010, 32'h99);
      cfg_beat(b1);
      chk("other_op_b1", {cout_if.data_wr, cout_if.data}, {1'b1, b1});
      cfg_beat(mk_b2());
      chk("other_op_b2", {cout_if.data_wr, cout_if.data}, {1'b1, mk_b2()});

      cfg_write(32'h7000_0020, 32'h11);
      cfg_write(32'h7000_0001, 32'h1);
      cfg_write(32'h7000_0050, 32'h11);
      cfg_read("rd_proto0", 32'h7000_0010, 32'h11);
      cfg_read("rd_unmapped", 32'h7000_00F0, 32'hFFFF_FFFF);
      cfg_read("rd_mask", 32'h7000_0001, 32'h1);
      cfg_read("rd_glob0", 32'h7000_0000, 32'h0);
      cfg_read("rd_r7", 32'h7000_0017, 32'hFFFF_FFFF);
      cfg_read("rd_ch4", 32'h7000_0050, 32'hFFFF_FFFF);
      cfg_read("rd_other_blk", 32'h7100_0010, 32'hFFFF_FFFF);

      cfg_beat(mk_b2());
      chk("lone_b2", {cout_if.data_wr, cout_if.data}, {1'b1, mk_b2()});

      cfg_beat(mk_b1(3'b010, 8'h02, 8'd7, 32'h7000_0040, 32'h33));
      chk("drop_then_b1", cout_if.data_wr, 256'd0);
      cfg_read("rd_after_drop", 32'h7000_0040, 32'h33);

      start = 1'b1;
      send_pkt(8'd7, 8'h11, 12'd64, 32'h0, 32'd100);
      send_pkt(8'd7, 8'h11, 12'd64, 32'h0, 32'd250);
      send_pkt(8'd7, 8'h11, 12'd64, 32'h0, 32'd180);
      send_pkt(8'd7, 8'h22, 12'd64, 32'h0, 32'd5);
      send_pkt(8'd3, 8'h11, 12'd64, 32'h0, 32'd1);
      start = 1'b0;
      send_pkt(8'd7, 8'h11, 12'd64, 32'h0, 32'd7);
      start = 1'b1;
      cfg_read("cnt_bytes0", 32'h7000_0011, 32'd192);
      cfg_read("cnt_bytes0_hi", 32'h7000_0012, 32'd0);
      cfg_read("cnt_pkts0", 32'h7000_0013, 32'd3);
      cfg_read("cnt_min0", 32'h7000_0015, 32'd100);
      cfg_read("cnt_max0", 32'h7000_0016, 32'd250);
      cfg_read("cnt_bytes1_masked", 32'h7000_0021, 32'd0);

      cfg_write(32'h7000_0030, 32'h33);
      cfg_write(32'h7000_0001, 32'hF);
      send_pkt(8'd7, 8'h33, 12'd10, 32'hFFFF_FFF0, 32'h10);
      cfg_read("wrap_min2", 32'h7000_0035, 32'h20);
      cfg_read("wrap_max2", 32'h7000_0036, 32'h20);
      cfg_read("multi_pkts3", 32'h7000_0043, 32'd1);
      cfg_read("multi_bytes3", 32'h7000_0041, 32'd10);
      cfg_read("multi_pkts1", 32'h7000_0023, 32'd0);

      dut.g_chan[0].u_chan.bytes_q = 64'h1_FFFF_FFF0;
      cfg_read("snap_lo", 32'h7000_0011, 32'hFFFF_FFF0);
      send_pkt(8'd7, 8'h11, 12'h020, 32'h0, 32'd50);
      cfg_read("snap_hi", 32'h7000_0012, 32'd1);
      cfg_read("snap_lo2", 32'h7000_0011, 32'h10);
      cfg_read("snap_hi2", 32'h7000_0012, 32'd2);
      cfg_read("snap_pkts", 32'h7000_0013, 32'd4);
      cfg_read("snap_pkts_hi", 32'h7000_0014, 32'd0);
      cfg_read("pre_clr_pkts1", 32'h7000_0023, 32'd1);

      pin_if.md      = mk_md(8'd7, 8'h11, 12'd64);
      pin_if.phv     = mk_phv(32'h0, 32'h2222_0000);
      pin_if.md_wr   = 1'b1;
      pin_if.phv_wr  = 1'b1;
      ts             = 32'd20;
      cin_if.data    = mk_b1(3'b010, 8'h02, 8'd7, 32'h7000_0000, 32'h1);
      cin_if.data_wr = 1'b1;
      tick();
      chk("clr_fwd", {pout_if.md_wr, pout_if.md[87:80]}, {1'b1, 8'd4});
      chk("clr_cout", cout_if.data_wr, 256'd0);
      pin_if.md_wr  = 1'b0;
      pin_if.phv_wr = 1'b0;
      cfg_beat(mk_b2());
      cfg_read("clr_bytes0", 32'h7000_0011, 32'd0);
      cfg_read("clr_pkts0", 32'h7000_0013, 32'd0);
      cfg_read("clr_min0", 32'h7000_0015, 32'hFFFF_FFFF);
      cfg_read("clr_max0", 32'h7000_0016, 32'd0);
      cfg_read("clr_pkts1", 32'h7000_0023, 32'd0);
      cfg_read("clr_pkts3", 32'h7000_0043, 32'd0);
      cfg_read("clr_mask_kept", 32'h7000_0001, 32'hF);

      cin_if.data    = mk_b1(3'b001, 8'h02, 8'd7, 32'h7000_0010, 32'h0);
      cin_if.data_wr = 1'b1;
      #2;
      rst_n = 1'b0;
      tick();
      chk("rst_mid_wr", cout_if.data_wr, 256'd0);
      cin_if.data_wr = 1'b0;
      cin_if.data    = '0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_after_wr", {cout_if.data_wr, cout_if.data}, 256'd0);
      end
      cfg_read("rst_proto0", 32'h7000_0010, 32'd0);
      cfg_read("rst_mask", 32'h7000_0001, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
